mux4_rr_arbiter: RTL and testbench

//   Shares one WIDTH-bit output channel among four valid/ready requesters.

---
 rtl/mux4_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Shares one WIDTH-bit valid/ready output channel among four requesters.
//   A round-robin arbiter picks a requester from IDLE and keeps that grant for
//   the whole burst, until the requester's in_last beat is accepted. The grant
//   drives the select of an internal mux4. The chosen word is captured in a
//   registered output stage that can take one word per cycle.
//
// Ports
//   clk        in   1        clock, all state changes on posedge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   4        per-requester valid (bit i = requester i)
//   in_last    in   4        per-requester end-of-burst, qualified by in_valid
//   in_data    in   4*WIDTH  requester i word on in_data[i*WIDTH +: WIDTH]
//   in_ready   out  4        per-requester accept, one-hot or zero
//   out_valid  out  1        registered output valid
//   out_last   out  1        registered end-of-burst marker
//   out_data   out  WIDTH    registered output word
//   out_ready  in   1        downstream accept
//   grant      out  2        currently granted requester (mux select)
//   busy       out  1        high while a burst is owned by a requester
// -----------------------------------------------------------------------------

// Plain 4:1 word multiplexer driven by the arbiter grant.
module mux4 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]         i_sel,
  input  logic [4*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]   o_data
);

  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    o_data = i_data[WIDTH-1:0];
    case (i_sel)
      2'd1:    o_data = i_data[1*WIDTH +: WIDTH];
      2'd2:    o_data = i_data[2*WIDTH +: WIDTH];
      2'd3:    o_data = i_data[3*WIDTH +: WIDTH];
      default: o_data = i_data[0*WIDTH +: WIDTH];
    endcase
  end

endmodule

module mux4_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [3:0]         in_last,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic               out_last,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [1:0]         grant,
  output logic               busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t             r_state;
  logic [1:0]         r_grant;
  logic [1:0]         r_last_grant;
  logic               r_out_valid;
  logic               r_out_last;
  logic [WIDTH-1:0]   r_out_data;

  logic [WIDTH-1:0]   w_mux_data;
  logic [1:0]         w_pick;
  logic               w_can_accept;
  logic [3:0]         w_in_ready;
  logic               w_in_beat;

  // Round-robin search: the first requesting index after last, wrapping.
  // Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  mux4 #(.WIDTH(WIDTH)) u_mux4 (
    .i_sel  (r_grant),
    .i_data (in_data),
    .o_data (w_mux_data)
  );

  always_comb begin
    w_pick       = rr_pick(in_valid, r_last_grant);
    // The output stage takes a new word when empty or draining this cycle.
    w_can_accept = !r_out_valid || out_ready;
    w_in_ready   = 4'b0000;
    if (r_state == ST_BUSY && w_can_accept) w_in_ready[r_grant] = 1'b1;
    w_in_beat    = |(in_valid & w_in_ready);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= 2'd0;
      r_last_grant <= 2'd3;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
    end else begin
      // Output register: reload on an input beat, even when the held word
      // leaves in the same cycle. This gives one beat per cycle.
      if (w_in_beat) begin
        r_out_data  <= w_mux_data;
        r_out_last  <= in_last[r_grant];
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (|in_valid) begin
            r_grant <= w_pick;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The grant stays locked through valid gaps and ends only on an
          // accepted last beat.
          if (w_in_beat && in_last[r_grant]) begin
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign grant     = r_grant;
  assign busy      = (r_state == ST_BUSY);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//   Directed bench for mux4_rr_arbiter. A table of per-cycle vectors covers
//   reset, a single-beat transfer, and round-robin rotation with wrap. Short
//   hand-written sequences cover a locked burst, output backpressure, a valid
//   gap inside a burst, and reset in the middle of a burst.
//   Inputs are driven, then after #1 the outputs are compared against
//   hand-computed values. The clock edge follows the comparison.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [3:0]       in_valid;
  logic [3:0]       in_last;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic             out_last;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       grant;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [3:0]  il;
    logic [31:0] data;
    logic        ordy;
    bit          chk;
    logic [1:0]  g;
    logic        b;
    logic [3:0]  ir;
    logic        ov;
    logic        ol;
    logic [7:0]  od;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] iv, input logic [3:0] il,
                       input logic [31:0] d, input logic ordy);
    rst       = r;
    in_valid  = iv;
    in_last   = il;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [1:0] g, input logic b,
                            input logic [3:0] ir, input logic ov, input logic ol,
                            input logic [7:0] od);
    check({tag, ".grant"},     32'(grant),     32'(g));
    check({tag, ".busy"},      32'(busy),      32'(b));
    check({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_last"},  32'(out_last),  32'(ol));
    check({tag, ".out_data"},  32'(out_data),  32'(od));
  endtask

  initial begin
    // rst iv il data ordy chk | grant busy in_ready out_valid out_last out_data
    // Test 1: single-beat transfer after reset.
    vecs.push_back('{1'b1, 4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 4'h1, 4'h1, 32'h000000A5, 1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 4'h1, 4'h1, 32'h000000A5, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 1'b1, 1'b1, 8'hA5});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1, 8'hA5});
    // Test 2: all four requesting, single-beat bursts, grants 0,1,2,3,0.
    vecs.push_back('{1'b1, 4'h0, 4'h0, 32'h0,        1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 32'h23222120, 1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 32'h23222120, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1, 1'b0, 1'b0, 8'h00});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 32'h23222120, 1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 1'b1, 1'b1, 8'h20});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 32'h23222120, 1'b1, 1'b1, 2'd1, 1'b1, 4'h2, 1'b0, 1'b1, 8'h20});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 32'h23222120, 1'b1, 1'b1, 2'd1, 1'b0, 4'h0, 1'b1, 1'b1, 8'h21});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 32'h23222120, 1'b1, 1'b1, 2'd2, 1'b1, 4'h4, 1'b0, 1'b1, 8'h21});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 32'h23222120, 1'b1, 1'b1, 2'd2, 1'b0, 4'h0, 1'b1, 1'b1, 8'h22});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 32'h23222120, 1'b1, 1'b1, 2'd3, 1'b1, 4'h8, 1'b0, 1'b1, 8'h22});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 32'h23222120, 1'b1, 1'b1, 2'd3, 1'b0, 4'h0, 1'b1, 1'b1, 8'h23});
    vecs.push_back('{1'b0, 4'hF, 4'hF, 32'h23222120, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1, 1'b0, 1'b1, 8'h23});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 1'b1, 1'b1, 8'h20});
    vecs.push_back('{1'b0, 4'h0, 4'h0, 32'h0,        1'b1, 1'b1, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1, 8'h20});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].il, vecs[i].data, vecs[i].ordy);
      if (vecs[i].chk)
        expect_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].b, vecs[i].ir,
                   vecs[i].ov, vecs[i].ol, vecs[i].od);
      tick();
    end

    // Test 3: requester 2 owns a 3-beat burst while requester 0 waits.
    drive(1'b0, 4'b0101, 4'b0001, 32'h00100030, 1'b1);
    check("t3.idle_busy", 32'(busy), 32'd0);
    tick();
    drive(1'b0, 4'b0101, 4'b0001, 32'h00100030, 1'b1);
    expect_all("t3.b0", 2'd2, 1'b1, 4'b0100, 1'b0, 1'b1, 8'h20);
    tick();
    drive(1'b0, 4'b0101, 4'b0001, 32'h00110030, 1'b1);
    expect_all("t3.b1", 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0, 8'h10);
    tick();
    drive(1'b0, 4'b0101, 4'b0101, 32'h00120030, 1'b1);
    expect_all("t3.b2", 2'd2, 1'b1, 4'b0100, 1'b1, 1'b0, 8'h11);
    tick();
    drive(1'b0, 4'b0001, 4'b0001, 32'h00000030, 1'b1);
    expect_all("t3.bubble", 2'd2, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h12);
    tick();
    drive(1'b0, 4'b0001, 4'b0001, 32'h00000030, 1'b1);
    expect_all("t3.next", 2'd0, 1'b1, 4'b0001, 1'b0, 1'b1, 8'h12);
    tick();
    drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
    expect_all("t3.out", 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h30);
    tick();

    // Test 4: backpressure on the output during a requester 3 burst.
    drive(1'b0, 4'b1000, 4'b0000, 32'h40000000, 1'b1);
    check("t4.idle_busy", 32'(busy), 32'd0);
    tick();
    drive(1'b0, 4'b1000, 4'b0000, 32'h40000000, 1'b1);
    expect_all("t4.b0", 2'd3, 1'b1, 4'b1000, 1'b0, 1'b1, 8'h30);
    tick();
    drive(1'b0, 4'b1000, 4'b0000, 32'h41000000, 1'b0);
    expect_all("t4.stall0", 2'd3, 1'b1, 4'b0000, 1'b1, 1'b0, 8'h40);
    tick();
    drive(1'b0, 4'b1000, 4'b0000, 32'h41000000, 1'b0);
    expect_all("t4.stall1", 2'd3, 1'b1, 4'b0000, 1'b1, 1'b0, 8'h40);
    tick();
    drive(1'b0, 4'b1000, 4'b0000, 32'h41000000, 1'b1);
    expect_all("t4.drain40", 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0, 8'h40);
    tick();
    drive(1'b0, 4'b1000, 4'b1000, 32'h42000000, 1'b1);
    expect_all("t4.drain41", 2'd3, 1'b1, 4'b1000, 1'b1, 1'b0, 8'h41);
    tick();
    drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b0);
    expect_all("t4.hold42", 2'd3, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h42);
    tick();
    drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
    expect_all("t4.drain42", 2'd3, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h42);
    tick();
    drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
    check("t4.empty", 32'(out_valid), 32'd0);
    tick();

    // Test 5: requester 1 pauses for two cycles mid-burst, grant stays put.
    drive(1'b0, 4'b0110, 4'b0000, 32'h00605000, 1'b1);
    check("t5.idle_busy", 32'(busy), 32'd0);
    tick();
    drive(1'b0, 4'b0110, 4'b0000, 32'h00605000, 1'b1);
    expect_all("t5.b0", 2'd1, 1'b1, 4'b0010, 1'b0, 1'b1, 8'h42);
    tick();
    drive(1'b0, 4'b0100, 4'b0000, 32'h00600000, 1'b1);
    expect_all("t5.gap0", 2'd1, 1'b1, 4'b0010, 1'b1, 1'b0, 8'h50);
    tick();
    drive(1'b0, 4'b0100, 4'b0000, 32'h00600000, 1'b1);
    expect_all("t5.gap1", 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0, 8'h50);
    tick();
    drive(1'b0, 4'b0110, 4'b0010, 32'h00605100, 1'b1);
    expect_all("t5.resume", 2'd1, 1'b1, 4'b0010, 1'b0, 1'b0, 8'h50);
    tick();
    drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
    expect_all("t5.out", 2'd1, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h51);
    tick();

    // Test 6: reset while requester 2 holds the grant and a word is pending.
    drive(1'b0, 4'b0100, 4'b0000, 32'h00700000, 1'b1);
    check("t6.idle_busy", 32'(busy), 32'd0);
    tick();
    drive(1'b0, 4'b0100, 4'b0000, 32'h00700000, 1'b1);
    expect_all("t6.b0", 2'd2, 1'b1, 4'b0100, 1'b0, 1'b1, 8'h51);
    tick();
    drive(1'b1, 4'b0100, 4'b0000, 32'h00710000, 1'b0);
    expect_all("t6.pre_rst", 2'd2, 1'b1, 4'b0000, 1'b1, 1'b0, 8'h70);
    tick();
    drive(1'b0, 4'b1111, 4'b1111, 32'h00000080, 1'b1);
    expect_all("t6.post_rst", 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b0, 4'b1111, 4'b1111, 32'h00000080, 1'b1);
    expect_all("t6.regrant", 2'd0, 1'b1, 4'b0001, 1'b0, 1'b0, 8'h00);
    tick();
    drive(1'b0, 4'b0000, 4'b0000, 32'h0, 1'b1);
    expect_all("t6.out", 2'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h80);
    tick();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
